// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: frame format constants, FSM encoding and command-byte builder
package instr_enc_pkg;
  localparam int RW_BIT = 7;
  localparam int ADDR_MSB = 5;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;
  typedef enum logic [3:0] {
    IDLE, CMD_TX, CMD_RX, DAT_TX, DAT_RX,
    NOP_CMD_TX, NOP_CMD_RX, NOP_DAT_TX, NOP_DAT_RX, DONE
  } state_e;
  function automatic logic [7:0] cmd_byte(input logic rw, input logic [ADDR_MSB:0] addr);
    logic [7:0] b;
    b = '0;
    b[RW_BIT] = rw;
    b[ADDR_MSB:0] = addr;
    return b;
  endfunction
  function automatic logic is_tx(input state_e s);
    return s inside {CMD_TX, DAT_TX, NOP_CMD_TX, NOP_DAT_TX};
  endfunction
  function automatic logic is_rx(input state_e s);
    return s inside {CMD_RX, DAT_RX, NOP_CMD_RX, NOP_DAT_RX};
  endfunction
endpackage

// File: rtl/instr_enc_if.sv
// instr_enc_if: host request/response and SPI byte-engine signals of the encoder
interface instr_enc_if;
  import instr_enc_pkg::*;
  logic req_valid, req_ready, req_write;
  logic [ADDR_MSB:0] req_addr;
  logic [7:0] req_wdata;
  logic rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic tx_valid, tx_ready;
  logic [7:0] tx_byte;
  logic rx_valid;
  logic [7:0] rx_byte;
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, tx_ready, rx_valid, rx_byte,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, tx_valid, tx_byte
  );
  modport master (
    output req_valid, req_write, req_addr, req_wdata, tx_ready, rx_valid, rx_byte,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, tx_valid, tx_byte
  );
endinterface

// File: rtl/instr_enc_timer.sv
// instr_enc_timer: saturating wait counter; expired flags the MAX-th waited cycle
module instr_enc_timer #(
  parameter int MAX = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign expired_o = en_i && cnt_q >= W'(MAX - 1);
endmodule

// File: rtl/instr_enc.sv
// instr_enc: serialises one register read/write into SPI command/data frames
module instr_enc
  import instr_enc_pkg::*;
#(
  parameter logic [ADDR_MSB:0] NOP_ADDR = 6'h3F,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  instr_enc_if.slave bus
);
  state_e state_q, state_d;
  logic wr_q, wr_d, tx_valid_q, err_q, expired, hs, accept;
  logic [7:0] wdata_q, wdata_d, tx_byte_q, tx_byte_d, rdata_q, rdata_d;
  assign bus.req_ready = state_q == IDLE && !rst;
  assign accept = bus.req_valid && bus.req_ready;
  assign hs = tx_valid_q && bus.tx_ready;
  always_comb begin
    state_d = state_q;
    wr_d = wr_q;
    wdata_d = wdata_q;
    tx_byte_d = tx_byte_q;
    rdata_d = rdata_q;
    if (expired) state_d = DONE;
    else case (state_q)
      IDLE: if (accept) begin
        state_d = CMD_TX;
        wr_d = bus.req_write;
        wdata_d = bus.req_wdata;
        tx_byte_d = cmd_byte(bus.req_write, bus.req_addr);
      end
      CMD_TX: if (hs) state_d = CMD_RX;
      CMD_RX: if (bus.rx_valid) begin
        state_d = DAT_TX;
        tx_byte_d = wr_q ? wdata_q : DUMMY_BYTE;
      end
      DAT_TX: if (hs) state_d = DAT_RX;
      // reads need a flush frame to clock out the data latched by the slave
      DAT_RX: if (bus.rx_valid) begin
        state_d = wr_q ? DONE : NOP_CMD_TX;
        tx_byte_d = wr_q ? tx_byte_q : cmd_byte(1'b0, NOP_ADDR);
      end
      NOP_CMD_TX: if (hs) state_d = NOP_CMD_RX;
      NOP_CMD_RX: if (bus.rx_valid) begin
        state_d = NOP_DAT_TX;
        rdata_d = bus.rx_byte;
        tx_byte_d = DUMMY_BYTE;
      end
      NOP_DAT_TX: if (hs) state_d = NOP_DAT_RX;
      NOP_DAT_RX: if (bus.rx_valid) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= 1'b0;
      wdata_q <= '0;
      tx_byte_q <= '0;
      rdata_q <= '0;
      tx_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      wdata_q <= wdata_d;
      tx_byte_q <= tx_byte_d;
      rdata_q <= rdata_d;
      tx_valid_q <= is_tx(state_d);
      err_q <= expired;
    end
  end
  instr_enc_timer #(.MAX(TIMEOUT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr_i(state_d != state_q),
    .en_i(is_tx(state_q) || is_rx(state_q)),
    .expired_o(expired)
  );
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_byte = tx_byte_q;
  assign bus.rsp_valid = state_q == DONE;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err = err_q;
endmodule

// File: tb/tb_instr_enc.sv
// tb_instr_enc: directed checks of instr_enc framing, stalls, timeout and reset
module tb_instr_enc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  instr_enc_if b0 ();
  instr_enc_if b1 ();
  instr_enc u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  instr_enc #(.NOP_ADDR(6'h3F), .TIMEOUT(16)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;

  task automatic send(input logic w, input logic [5:0] a, input logic [7:0] d, output logic ok);
    b0.req_valid = 1'b1;
    b0.req_write = w;
    b0.req_addr = a;
    b0.req_wdata = d;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = b0.req_ready;
      @(negedge clk);
    end
    b0.req_valid = 1'b0;
    b0.req_write = ~w;
    b0.req_addr = ~a;
    b0.req_wdata = ~d;
  endtask

  task automatic xfer(input int hold, input int lat, input logic [7:0] miso,
                      output logic [7:0] sent, output logic ok, output logic stable, output logic dropped);
    ok = 1'b0;
    stable = 1'b1;
    dropped = 1'b0;
    sent = 8'hxx;
    for (int i = 0; i < 200 && b0.tx_valid !== 1'b1; i++) @(negedge clk);
    if (b0.tx_valid !== 1'b1) return;
    sent = b0.tx_byte;
    repeat (hold) begin
      @(negedge clk);
      if (b0.tx_valid !== 1'b1 || b0.tx_byte !== sent) stable = 1'b0;
    end
    b0.tx_ready = 1'b1;
    @(negedge clk);
    b0.tx_ready = 1'b0;
    dropped = b0.tx_valid === 1'b0;
    repeat (lat - 1) @(negedge clk);
    b0.rx_valid = 1'b1;
    b0.rx_byte = miso;
    @(negedge clk);
    b0.rx_valid = 1'b0;
    b0.rx_byte = 8'h00;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({b0.req_ready, b0.tx_valid, b0.tx_byte, b0.rsp_valid, b0.rsp_rdata, b0.rsp_err} !== 20'h0) begin
      n_bad++;
      $display("FAIL rst_b0: got %h want 0", {b0.req_ready, b0.tx_valid, b0.tx_byte, b0.rsp_valid, b0.rsp_rdata, b0.rsp_err});
    end
    n_cmp++;
    if ({b1.req_ready, b1.tx_valid, b1.tx_byte, b1.rsp_valid, b1.rsp_rdata, b1.rsp_err} !== 20'h0) begin
      n_bad++;
      $display("FAIL rst_b1: got %h want 0", {b1.req_ready, b1.tx_valid, b1.tx_byte, b1.rsp_valid, b1.rsp_rdata, b1.rsp_err});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({b0.req_ready, b1.req_ready, b0.tx_valid} !== 3'b110) begin
      n_bad++;
      $display("FAIL rst_release: got %b want 110", {b0.req_ready, b1.req_ready, b0.tx_valid});
    end
  endtask

  task automatic test_write();
    logic [7:0] s;
    logic ok, st, dr, seen;
    send(1'b1, 6'h05, 8'hA7, ok);
    xfer(0, 3, 8'h00, s, ok, st, dr);
    n_cmp++;
    if ({ok, dr, s} !== {1'b1, 1'b1, 8'h85}) begin
      n_bad++;
      $display("FAIL wr_cmd: got %h want %h", {ok, dr, s}, {1'b1, 1'b1, 8'h85});
    end
    xfer(0, 3, 8'h00, s, ok, st, dr);
    n_cmp++;
    if ({ok, dr, s} !== {1'b1, 1'b1, 8'hA7}) begin
      n_bad++;
      $display("FAIL wr_data: got %h want %h", {ok, dr, s}, {1'b1, 1'b1, 8'hA7});
    end
    n_cmp++;
    if ({b0.rsp_valid, b0.rsp_err, b0.req_ready} !== 3'b100) begin
      n_bad++;
      $display("FAIL wr_rsp: got %b want 100", {b0.rsp_valid, b0.rsp_err, b0.req_ready});
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | b0.tx_valid | b0.rsp_valid | !b0.req_ready;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_no_flush: got %b want 0", seen);
    end
  endtask

  task automatic test_read();
    logic [7:0] s;
    logic [7:0] exp_tx [4] = '{8'h02, 8'h00, 8'h3F, 8'h00};
    logic [7:0] miso [4] = '{8'h00, 8'h11, 8'h3C, 8'hEE};
    logic ok, st, dr;
    send(1'b0, 6'h02, 8'hFF, ok);
    for (int i = 0; i < 4; i++) begin
      xfer(0, 2, miso[i], s, ok, st, dr);
      n_cmp++;
      if ({ok, dr, s} !== {1'b1, 1'b1, exp_tx[i]}) begin
        n_bad++;
        $display("FAIL rd_byte%0d: got %h want %h", i, {ok, dr, s}, {1'b1, 1'b1, exp_tx[i]});
      end
    end
    n_cmp++;
    if ({b0.rsp_valid, b0.rsp_err, b0.rsp_rdata} !== {1'b1, 1'b0, 8'h3C}) begin
      n_bad++;
      $display("FAIL rd_rsp: got %h want %h", {b0.rsp_valid, b0.rsp_err, b0.rsp_rdata}, {1'b1, 1'b0, 8'h3C});
    end
    @(negedge clk);
    n_cmp++;
    if ({b0.rsp_valid, b0.req_ready, b0.rsp_rdata} !== {1'b0, 1'b1, 8'h3C}) begin
      n_bad++;
      $display("FAIL rd_after: got %h want %h", {b0.rsp_valid, b0.req_ready, b0.rsp_rdata}, {1'b0, 1'b1, 8'h3C});
    end
  endtask

  task automatic test_stall();
    logic [7:0] s;
    logic ok, st, dr;
    send(1'b1, 6'h10, 8'h5A, ok);
    xfer(50, 2, 8'h00, s, ok, st, dr);
    n_cmp++;
    if ({ok, st, dr, s} !== {1'b1, 1'b1, 1'b1, 8'h90}) begin
      n_bad++;
      $display("FAIL stall_cmd: got %h want %h", {ok, st, dr, s}, {1'b1, 1'b1, 1'b1, 8'h90});
    end
    xfer(0, 2, 8'h00, s, ok, st, dr);
    n_cmp++;
    if ({ok, s, b0.rsp_valid, b0.rsp_err, b0.rsp_rdata} !== {1'b1, 8'h5A, 1'b1, 1'b0, 8'h3C}) begin
      n_bad++;
      $display("FAIL stall_done: got %h want %h", {ok, s, b0.rsp_valid, b0.rsp_err, b0.rsp_rdata}, {1'b1, 8'h5A, 1'b1, 1'b0, 8'h3C});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    logic [7:0] exp_tx [6] = '{8'hA1, 8'hC3, 8'h07, 8'h00, 8'h3F, 8'h00};
    logic [7:0] miso [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h96, 8'h55};
    logic ok, st, dr;
    b0.req_valid = 1'b1;
    b0.req_write = 1'b1;
    b0.req_addr = 6'h21;
    b0.req_wdata = 8'hC3;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = b0.req_ready;
      @(negedge clk);
    end
    b0.req_write = 1'b0;
    b0.req_addr = 6'h07;
    b0.req_wdata = 8'h00;
    for (int i = 0; i < 6; i++) begin
      xfer(0, 2, miso[i], s, ok, st, dr);
      n_cmp++;
      if ({ok, s} !== {1'b1, exp_tx[i]}) begin
        n_bad++;
        $display("FAIL b2b_byte%0d: got %h want %h", i, {ok, s}, {1'b1, exp_tx[i]});
      end
      if (i == 1) begin
        n_cmp++;
        if ({b0.rsp_valid, b0.req_ready} !== 2'b10) begin
          n_bad++;
          $display("FAIL b2b_wr_rsp: got %b want 10", {b0.rsp_valid, b0.req_ready});
        end
        @(negedge clk);
        n_cmp++;
        if ({b0.rsp_valid, b0.req_ready, b0.tx_valid} !== 3'b010) begin
          n_bad++;
          $display("FAIL b2b_idle: got %b want 010", {b0.rsp_valid, b0.req_ready, b0.tx_valid});
        end
        @(negedge clk);
        b0.req_valid = 1'b0;
      end
    end
    n_cmp++;
    if ({b0.rsp_valid, b0.rsp_err, b0.rsp_rdata} !== {1'b1, 1'b0, 8'h96}) begin
      n_bad++;
      $display("FAIL b2b_rd_rsp: got %h want %h", {b0.rsp_valid, b0.rsp_err, b0.rsp_rdata}, {1'b1, 1'b0, 8'h96});
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic ok;
    int k;
    b1.req_valid = 1'b1;
    b1.req_write = 1'b0;
    b1.req_addr = 6'h03;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = b1.req_ready;
      @(negedge clk);
    end
    b1.req_valid = 1'b0;
    n_cmp++;
    if ({b1.tx_valid, b1.tx_byte} !== {1'b1, 8'h03}) begin
      n_bad++;
      $display("FAIL to_cmd: got %h want %h", {b1.tx_valid, b1.tx_byte}, {1'b1, 8'h03});
    end
    b1.tx_ready = 1'b1;
    @(negedge clk);
    b1.tx_ready = 1'b0;
    k = 1;
    while (b1.rsp_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if ({k, b1.rsp_valid, b1.rsp_err, b1.tx_valid, b1.rsp_rdata} !== {32'd17, 1'b1, 1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL to_rsp: got cyc=%0d v=%b e=%b txv=%b rd=%h want cyc=17 v=1 e=1 txv=0 rd=00",
               k, b1.rsp_valid, b1.rsp_err, b1.tx_valid, b1.rsp_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({b1.req_ready, b1.rsp_valid, b1.rsp_err} !== 3'b100) begin
      n_bad++;
      $display("FAIL to_after: got %b want 100", {b1.req_ready, b1.rsp_valid, b1.rsp_err});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s;
    logic ok, st, dr, seen;
    send(1'b0, 6'h0A, 8'h00, ok);
    xfer(0, 2, 8'h00, s, ok, st, dr);
    n_cmp++;
    if ({ok, s, b0.tx_valid, b0.tx_byte} !== {1'b1, 8'h0A, 1'b1, 8'h00}) begin
      n_bad++;
      $display("FAIL rm_pre: got %h want %h", {ok, s, b0.tx_valid, b0.tx_byte}, {1'b1, 8'h0A, 1'b1, 8'h00});
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({b0.tx_valid, b0.tx_byte, b0.rsp_valid, b0.rsp_rdata, b0.rsp_err, b0.req_ready} !== 20'h0) begin
      n_bad++;
      $display("FAIL rm_rst: got %h want 0", {b0.tx_valid, b0.tx_byte, b0.rsp_valid, b0.rsp_rdata, b0.rsp_err, b0.req_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b0.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rm_ready: got %b want 1", b0.req_ready);
    end
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | b0.rsp_valid | b0.tx_valid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_quiet: got %b want 0", seen);
    end
  endtask

  initial begin
    {b0.req_valid, b0.req_write, b0.req_addr, b0.req_wdata, b0.tx_ready, b0.rx_valid, b0.rx_byte} = '0;
    {b1.req_valid, b1.req_write, b1.req_addr, b1.req_wdata, b1.tx_ready, b1.rx_valid, b1.rx_byte} = '0;
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
